// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_be(input logic size, input logic [1:0] off);
        if (size == SIZE_BYTE)
            return 4'b0001 << off;
        return 4'hF;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the load result from a 32-bit memory word: whole word, or one zero-extended byte lane.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic        size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = rdata_i;
        if (size_i == SIZE_BYTE)
            data_o = {24'b0, rdata_i[{off_i, 3'b000} +: 8]};
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: runs one req/ack transaction per access and stalls
// the upstream pipeline until it completes or times out.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              enable_i,
    input  logic              rw_i,
    input  logic              size_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_we;
    logic              r_size;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       w_load_data;
    logic              w_start;

    // Gated by CLR_N so stall_o is also low while reset is held.
    assign w_start = enable_i & ~flush_i & CLR_N;

    dmem_load_align u_load_align (
        .size_i  (r_size),
        .off_i   (r_addr[1:0]),
        .rdata_i (mem_rdata_i),
        .data_o  (w_load_data)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!CLR_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= SIZE_WORD;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= addr_i;
                        r_we    <= rw_i;
                        r_size  <= size_i;
                        r_be    <= lane_be(size_i, addr_i[1:0]);
                        r_wdata <= (size_i == SIZE_BYTE) ? {4{wdata_i[7:0]}} : wdata_i;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack_i) begin
                        if (!r_we)
                            r_rdata <= w_load_data;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o   = (r_state == ST_REQ);
    assign mem_we_o    = mem_req_o & r_we;
    assign mem_be_o    = mem_req_o ? r_be : 4'h0;
    assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = r_wdata;
    assign stall_o     = ((r_state == ST_IDLE) & w_start) | mem_req_o;
    assign rdata_o     = r_rdata;
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = done_o & r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset/flush sequences,
// and randomized accesses checked against an arithmetic reference model.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        CLK;
    logic        CLR_N;
    logic        enable_i;
    logic        rw_i;
    logic        size_i;
    logic        flush_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata;

    dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .CLR_N       (CLR_N),
        .enable_i    (enable_i),
        .rw_i        (rw_i),
        .size_i      (size_i),
        .flush_i     (flush_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   32'(mem_req_o),   32'h0);
        check({tag, "_we"},    32'(mem_we_o),    32'h0);
        check({tag, "_be"},    32'(mem_be_o),    32'h0);
        check({tag, "_addr"},  mem_addr_o,       32'h0);
        check({tag, "_wdata"}, mem_wdata_o,      32'h0);
        check({tag, "_stall"}, 32'(stall_o),     32'h0);
        check({tag, "_rdata"}, rdata_o,          32'h0);
        check({tag, "_done"},  32'(done_o),      32'h0);
        check({tag, "_err"},   32'(err_o),       32'h0);
    endtask

    // Reference model: lane rules expressed as plain arithmetic on the byte offset.
    function automatic logic [3:0] ref_be(input logic size, input logic [31:0] addr);
        int lane = int'(addr % 4);
        return size ? 4'(1 << lane) : 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic size, input logic [31:0] wdata);
        return size ? ({24'b0, wdata[7:0]} * 32'h0101_0101) : wdata;
    endfunction

    function automatic logic [31:0] ref_load(input logic size, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int lane = int'(addr % 4);
        return size ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
    endfunction

    // Runs one access starting at an IDLE cycle (called just after a posedge).
    // ack_k: REQ cycle number in which memory acks (1..TIMEOUT), 0 for never.
    // Returns with the bench positioned in the DONE cycle.
    task automatic run_access(input string tag, input logic rw, input logic size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_k,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdo,
                              input logic e_err);
        int  n_req     = 0;
        int  stall_cnt = 0;
        bit  got_done  = 0;
        int  e_req     = (ack_k == 0) ? TIMEOUT : ack_k;

        check({tag, "_idle_req"}, 32'(mem_req_o), 32'h0);
        enable_i = 1'b1;
        flush_i  = 1'b0;
        rw_i     = rw;
        size_i   = size;
        addr_i   = addr;
        wdata_i  = wdata;
        #1;
        check({tag, "_idle_stall"}, 32'(stall_o), 32'h1);
        if (stall_o) stall_cnt++;

        for (int c = 0; c < TIMEOUT + 3; c++) begin
            @(posedge CLK);
            #1;
            mem_ack_i = 1'b0;
            if (done_o) begin
                got_done = 1;
                break;
            end
            n_req++;
            check({tag, "_req"},   32'(mem_req_o), 32'h1);
            check({tag, "_addr"},  mem_addr_o,     e_addr);
            check({tag, "_be"},    32'(mem_be_o),  32'(e_be));
            check({tag, "_we"},    32'(mem_we_o),  32'(rw));
            if (rw) check({tag, "_wdata"}, mem_wdata_o, e_wdata);
            if (stall_o) stall_cnt++;
            // Inputs are frozen in a real pipeline; scrambling them proves they are latched.
            addr_i  = $urandom;
            wdata_i = $urandom;
            rw_i    = 1'($urandom);
            size_i  = 1'($urandom);
            flush_i = 1'($urandom);
            mem_ack_i   = (n_req == ack_k);
            mem_rdata_i = (n_req == ack_k) ? rdata : $urandom;
        end

        check({tag, "_done_seen"}, 32'(got_done),  32'h1);
        check({tag, "_req_cycles"}, 32'(n_req),    32'(e_req));
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(e_req + 1));
        check({tag, "_done_stall"}, 32'(stall_o),  32'h0);
        check({tag, "_done_req"},  32'(mem_req_o), 32'h0);
        check({tag, "_err"},       32'(err_o),     32'(e_err));
        check({tag, "_rdata_o"},   rdata_o,        e_rdo);
        // Enable stays high through DONE; the next IDLE cycle must not show a request.
        enable_i = 1'b1;
        flush_i  = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        rw;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_k;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdo;
        logic        e_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{"word_ld",   1'b0, 1'b0, 32'h0000_0104, 32'h0,          32'hDEAD_BEEF, 2,
                   32'h0000_0104, 4'hF, 32'h0,          32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{"byte_st",   1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB, 32'h0,         1,
                   32'h0000_0200, 4'h8, 32'hABAB_ABAB, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{"byte_ld",   1'b0, 1'b1, 32'h0000_0002, 32'h0,          32'h1122_3344, 1,
                   32'h0000_0000, 4'h4, 32'h0,          32'h0000_0022, 1'b0};
        tbl[3] = '{"timeout",   1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h5555_5555, 0,
                   32'h0000_0010, 4'hF, 32'h0,          32'h0000_0022, 1'b1};
        tbl[4] = '{"misal_st",  1'b1, 1'b0, 32'h0000_0007, 32'h1234_5678, 32'h0,         3,
                   32'h0000_0004, 4'hF, 32'h1234_5678, 32'h0000_0022, 1'b0};
        tbl[5] = '{"ack_last",  1'b0, 1'b0, 32'h0000_0020, 32'h0,          32'hCAFE_F00D, TIMEOUT,
                   32'h0000_0020, 4'hF, 32'h0,          32'hCAFE_F00D, 1'b0};
        tbl[6] = '{"byte_ld3",  1'b0, 1'b1, 32'h0000_0013, 32'h0,          32'hA1B2_C3D4, 1,
                   32'h0000_0010, 4'h8, 32'h0,          32'h0000_00A1, 1'b0};

        CLR_N       = 1'b0;
        enable_i    = 1'b1;
        rw_i        = 1'b0;
        size_i      = 1'b0;
        flush_i     = 1'b0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        model_rdata = 32'h0;

        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        CLR_N    = 1'b1;
        enable_i = 1'b0;

        // Squashed instruction in IDLE: no stall, no request.
        @(posedge CLK);
        #1;
        enable_i = 1'b1;
        flush_i  = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'h0);
        @(posedge CLK);
        #1;
        check("flush_req", 32'(mem_req_o), 32'h0);
        enable_i = 1'b0;
        flush_i  = 1'b0;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
            run_access(tbl[i].name, tbl[i].rw, tbl[i].size, tbl[i].addr, tbl[i].wdata,
                       tbl[i].rdata, tbl[i].ack_k, tbl[i].e_addr, tbl[i].e_be,
                       tbl[i].e_wdata, tbl[i].e_rdo, tbl[i].e_err);
        end
        @(posedge CLK);
        #1;
        check("tail_idle_req", 32'(mem_req_o), 32'h0);
        enable_i = 1'b0;

        // Reset asserted mid-REQ, then a late ack after release.
        @(posedge CLK);
        #1;
        enable_i = 1'b1;
        rw_i     = 1'b1;
        size_i   = 1'b0;
        addr_i   = 32'h0000_0040;
        wdata_i  = 32'h0BAD_F00D;
        @(posedge CLK);
        #1;
        check("rst_mid_req_before", 32'(mem_req_o), 32'h1);
        @(posedge CLK);
        #3;
        CLR_N = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_rdata = 32'h0;
        enable_i    = 1'b0;
        @(negedge CLK);
        CLR_N = 1'b1;
        @(posedge CLK);
        #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1;
        mem_ack_i = 1'b0;
        check("late_ack_done", 32'(done_o), 32'h0);
        check("late_ack_req",  32'(mem_req_o), 32'h0);
        @(posedge CLK);
        #1;
        check("late_ack_done2", 32'(done_o), 32'h0);
        check("late_ack_rdata", rdata_o, 32'h0);

        // Randomized accesses against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic        rw    = 1'($urandom);
            logic        size  = 1'($urandom);
            logic [31:0] addr  = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] rdata = $urandom;
            int          k     = ($urandom_range(0, 9) == 0) ? 0 :
                                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, TIMEOUT) :
                                                               $urandom_range(1, 3);
            int          idle  = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                @(posedge CLK);
                #1;
                enable_i = 1'($urandom);
                flush_i  = enable_i ? 1'b1 : 1'($urandom);
                #1;
                check("rand_idle_stall", 32'(stall_o), 32'h0);
                check("rand_idle_req",   32'(mem_req_o), 32'h0);
            end
            if (!rw && k != 0)
                model_rdata = ref_load(size, addr, rdata);
            @(posedge CLK);
            #1;
            run_access("rand", rw, size, addr, wdata, rdata, k, addr & ~32'h3,
                       ref_be(size, addr), ref_wdata(size, wdata), model_rdata, k == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
